// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, state encoding and alignment helper for the data memory
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Byte accesses are always aligned; halfwords need addr[0]==0; words and
    // undefined encodings (handled as words) need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = addr_lo[0];
            default:     mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - load lane extract/extend and store lane merge
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane selection ignores the low address bits a wider access cannot use,
    // which is what aligns a misaligned halfword/word down to its boundary.
    always_comb begin
        sel_byte = mem_word[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h000000, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0000, sel_half};
            default: load_data = mem_word;
        endcase
    end

    // Merge the low byte/half of the store data into the addressed lanes,
    // preserving the rest of the word.
    always_comb begin
        store_word = mem_word;
        case (funct3)
            F3_B: store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            F3_H: begin
                if (addr_lo[1]) begin
                    store_word[31:16] = store_data[15:0];
                end else begin
                    store_word[15:0] = store_data[15:0];
                end
            end
            default: store_word = store_data;
        endcase
    end

endmodule

// File: rtl/data_memory_busywait.sv
// rtl/data_memory_busywait.sv - fixed-latency data memory behind the CPU BUSYWAIT handshake (option: DMEM_MISALIGN_TRAP_EN)
module data_memory_busywait
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,   // words, power of two
    parameter int LATENCY = 4      // BUSY cycles per access, 1..15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [31:0] MEM_ADDRESS,
    input  logic [31:0] MEM_WRITE_DATA,
    input  logic [2:0]  FUNCT3,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED
);

    localparam int AW = $clog2(DEPTH);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        write_q, write_d;
    logic [31:0] read_data_q, read_data_d;

    logic        busywait;
    logic        complete;
    logic        access_blocked;
    logic        mem_we;
    logic [31:0] cur_word;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic [AW-1:0] word_idx;
    logic        unused_addr_hi;

    logic [31:0] mem [DEPTH];

    // Word index wraps modulo DEPTH; the high address bits are deliberately dropped.
    assign word_idx       = addr_q[AW+1:2];
    assign unused_addr_hi = ^addr_q[31:AW+2];
    assign cur_word       = mem[word_idx];

    dmem_lane_align u_lane_align (
        .funct3     (f3_q),
        .addr_lo    (addr_q[1:0]),
        .mem_word   (cur_word),
        .store_data (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned_q;
    assign access_blocked = is_misaligned(f3_q, addr_q[1:0]);
    assign MISALIGNED     = misaligned_q;
`else
    assign access_blocked = 1'b0;
    assign MISALIGNED     = 1'b0;
`endif

    // Next-state, capture and stall logic; requests are sampled only in IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        write_d     = write_q;
        read_data_d = read_data_q;
        busywait    = 1'b0;
        complete    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busywait = MEM_READ | MEM_WRITE;
                if (MEM_READ | MEM_WRITE) begin
                    addr_d  = MEM_ADDRESS;
                    wdata_d = MEM_WRITE_DATA;
                    f3_d    = FUNCT3;
                    write_d = MEM_WRITE;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                busywait = 1'b1;
                if (cnt_q == 4'd0) begin
                    complete = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (complete && !write_q && !access_blocked) begin
            read_data_d = load_data;
        end
        if (RESET) begin
            busywait = 1'b0;
        end
    end

    assign BUSYWAIT  = busywait;
    assign READ_DATA = read_data_q;
    assign mem_we    = complete && write_q && !access_blocked && !RESET;

    // Control and result registers; reset aborts any access in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            f3_q        <= 3'd0;
            write_q     <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            write_q     <= write_d;
            read_data_q <= read_data_d;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Flag a refused access for exactly the DONE cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= complete && access_blocked;
        end
    end
`endif

    // Storage array is not reset; stores commit on the BUSY->DONE edge.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[word_idx] <= store_word;
        end
    end

endmodule

// File: tb/tb_data_memory_busywait.sv
// tb/tb_data_memory_busywait.sv - directed self-checking bench for data_memory_busywait
module tb_data_memory_busywait;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITE_DATA;
    logic [2:0]  FUNCT3;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    data_memory_busywait #(.DEPTH(256), .LATENCY(LAT)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_ADDRESS    (MEM_ADDRESS),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .FUNCT3         (FUNCT3),
        .READ_DATA      (READ_DATA),
        .BUSYWAIT       (BUSYWAIT),
        .MISALIGNED     (MISALIGNED)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request and count BUSYWAIT-high cycles; returns in the DONE cycle.
    // from_done: inputs are being applied during a DONE cycle (back-to-back).
    // chain: keep the request lines as they are on return.
    task automatic acc(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input bit from_done, input bit chain);
        int n;
        MEM_WRITE      = wr;
        MEM_READ       = rd;
        MEM_ADDRESS    = a;
        MEM_WRITE_DATA = d;
        FUNCT3         = f3;
        if (from_done) @(negedge CLK);
        else #1;
        n = 0;
        while (BUSYWAIT === 1'b1 && n < 40) begin
            n++;
            @(negedge CLK);
        end
        chk("stall_len", 32'(n), 32'(LAT + 1));
        if (!chain) begin
            MEM_READ  = 1'b0;
            MEM_WRITE = 1'b0;
        end
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        acc(1'b1, 1'b0, a, d, f3, 1'b0, 1'b0);
        @(negedge CLK);
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp);
        acc(1'b0, 1'b1, a, 32'd0, f3, 1'b0, 1'b0);
        chk(tag, READ_DATA, exp);
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; MEM_READ = 1'b1; MEM_WRITE = 1'b0;
        MEM_ADDRESS = 32'd0; MEM_WRITE_DATA = 32'd0; FUNCT3 = 3'b010;
        repeat (3) @(negedge CLK);
        chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("rst_read_data", READ_DATA, 32'd0);
        chk("rst_misaligned", {31'd0, MISALIGNED}, 32'd0);
        MEM_READ = 1'b0;
        RESET    = 1'b0;
        @(negedge CLK);

        // SW then LW back-to-back with a single low DONE cycle between them
        acc(1'b1, 1'b0, 32'h10, 32'h12345678, 3'b010, 1'b0, 1'b1);
        chk("gap_busywait", {31'd0, BUSYWAIT}, 32'd0);
        acc(1'b0, 1'b1, 32'h10, 32'd0, 3'b010, 1'b1, 1'b0);
        chk("lw_0x10", READ_DATA, 32'h12345678);
        chk("lw_misaligned", {31'd0, MISALIGNED}, 32'd0);
        @(negedge CLK);

        // Byte store and signed/unsigned byte loads
        st(32'h13, 32'hFFFFFF80, 3'b000);
        ld("lb_0x13", 32'h13, 3'b000, 32'hFFFFFF80);
        ld("lbu_0x13", 32'h13, 3'b100, 32'h00000080);
        ld("lw_after_sb", 32'h10, 3'b010, 32'h80345678);

        // Halfword store into upper half, lower half preserved
        st(32'h20, 32'h11223344, 3'b010);
        st(32'h22, 32'h1234BEEF, 3'b001);
        ld("lh_0x22", 32'h22, 3'b001, 32'hFFFFBEEF);
        ld("lhu_0x22", 32'h22, 3'b101, 32'h0000BEEF);
        ld("lw_after_sh", 32'h20, 3'b010, 32'hBEEF3344);

        // Reset during the second BUSY cycle of a store
        st(32'h40, 32'hCAFEF00D, 3'b010);
        ld("lw_0x40_pre", 32'h40, 3'b010, 32'hCAFEF00D);
        MEM_WRITE = 1'b1; MEM_READ = 1'b0;
        MEM_ADDRESS = 32'h40; MEM_WRITE_DATA = 32'hDEADBEEF; FUNCT3 = 3'b010;
        #1;
        chk("req_busywait", {31'd0, BUSYWAIT}, 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        chk("busy2_busywait", {31'd0, BUSYWAIT}, 32'd1);
        RESET = 1'b1; MEM_WRITE = 1'b0;
        #1;
        chk("rst_mid_busywait", {31'd0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        chk("post_rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("post_rst_read_data", READ_DATA, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        ld("lw_0x40_post_rst", 32'h40, 3'b010, 32'hCAFEF00D);

        // Misaligned word load and halfword store
        ld("lw_0x10_again", 32'h10, 3'b010, 32'h80345678);
        acc(1'b0, 1'b1, 32'h41, 32'd0, 3'b010, 1'b0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lw_0x41_data", READ_DATA, 32'h80345678);
        chk("lw_0x41_misaligned", {31'd0, MISALIGNED}, 32'd1);
`else
        chk("lw_0x41_data", READ_DATA, 32'hCAFEF00D);
        chk("lw_0x41_misaligned", {31'd0, MISALIGNED}, 32'd0);
`endif
        @(negedge CLK);
        chk("misaligned_pulse_end", {31'd0, MISALIGNED}, 32'd0);
        acc(1'b1, 1'b0, 32'h21, 32'h00000000, 3'b001, 1'b0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("sh_0x21_misaligned", {31'd0, MISALIGNED}, 32'd1);
        @(negedge CLK);
        ld("lw_after_sh_0x21", 32'h20, 3'b010, 32'hBEEF3344);
`else
        chk("sh_0x21_misaligned", {31'd0, MISALIGNED}, 32'd0);
        @(negedge CLK);
        ld("lw_after_sh_0x21", 32'h20, 3'b010, 32'hBEEF0000);
`endif

        // Index wrap: 0x400 maps to word 0 with DEPTH=256
        st(32'h400, 32'hA5A5A5A5, 3'b010);
        ld("lw_wrap_0x000", 32'h000, 3'b010, 32'hA5A5A5A5);

        // Read and write together: treated as a store, READ_DATA untouched
        acc(1'b1, 1'b1, 32'h000, 32'h01020304, 3'b010, 1'b0, 1'b0);
        chk("rw_read_data", READ_DATA, 32'hA5A5A5A5);
        @(negedge CLK);
        ld("lw_after_rw", 32'h000, 3'b010, 32'h01020304);

        // Undefined FUNCT3 on a load behaves as a word load
        ld("ld_f3_011", 32'h10, 3'b011, 32'h80345678);
        ld("ld_f3_111", 32'h20, 3'b111, 32'hBEEF3344 ^ 32'h0000_0000 ^ (32'hBEEF3344 ^ READ_DATA_EXP_0x20()));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Expected word at 0x20 at the end of the run, depending on the build option.
    function automatic logic [31:0] READ_DATA_EXP_0x20();
`ifdef DMEM_MISALIGN_TRAP_EN
        return 32'hBEEF3344;
`else
        return 32'hBEEF0000;
`endif
    endfunction

endmodule

// File: doc/data_memory_busywait.md
Name: data_memory_busywait

Overview:
- Data-memory responder for the CPU's data port: the target end of the CPU's MEM_READ/MEM_WRITE/BUSYWAIT handshake.
- Accepts one load or store at a time, stalls the pipeline via BUSYWAIT for a fixed latency, then commits the store or returns load data.
- Supports RV32IM byte, halfword and word accesses, including sign/zero extension on loads.
- Replaces the testbench-driven READ_DATA/BUSYWAIT stimulus in CPU-level simulation.

Parameters:
- DEPTH, 256, number of 32-bit words; word index = MEM_ADDRESS[31:2] modulo DEPTH (wraps).
- LATENCY, 4, cycles in BUSY state per access; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- MEM_READ  in  1  load request; level, held by CPU until BUSYWAIT low.
- MEM_WRITE  in  1  store request; level, held by CPU until BUSYWAIT low.
- MEM_ADDRESS  in  32  byte address.
- MEM_WRITE_DATA  in  32  store data; byte/half taken from low bits.
- FUNCT3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- READ_DATA  out  32  load result, registered.
- BUSYWAIT  out  1  stall request to CPU.
- MISALIGNED  out  1  one-cycle pulse, registered, on a misaligned access.

Behaviour:
- Reset values: READ_DATA=0, MISALIGNED=0, state IDLE, counter 0. BUSYWAIT=0 while RESET high. Array contents are not reset; simulation initialises them to 0.
- States:
  - IDLE: BUSYWAIT = MEM_READ|MEM_WRITE (combinational), so the stall starts in the request cycle. On the edge with a request, capture address, data, FUNCT3 and op; set counter=LATENCY-1; go to BUSY.
  - BUSY: BUSYWAIT=1. Counter decrements each edge. At the edge where counter==0, perform the access and go to DONE.
  - DONE: BUSYWAIT=0 regardless of request, so the CPU advances on this edge. Next state is IDLE; no new request is accepted in DONE.
- Stall length: BUSYWAIT is high for exactly LATENCY+1 consecutive cycles per access, followed by one low DONE cycle. Back-to-back accesses are separated by that single DONE cycle.
- Inputs are sampled only at acceptance. Changes during BUSY are ignored.
- MEM_READ and MEM_WRITE both high: treated as a write; no READ_DATA update.
- Store:
  - SB writes byte lane addr[1:0].
  - SH writes lanes {addr[1],0}/{addr[1],1}.
  - SW writes all lanes.
  - Other bytes of the word are preserved.
- Load:
  - B/BU select byte addr[1:0] with sign/zero extension to 32 bits.
  - H/HU select half addr[1] with sign/zero extension.
  - W returns the full word.
  - Undefined FUNCT3 encodings are treated as W.
  - READ_DATA updates at the BUSY->DONE edge and holds until the next completed load.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0 (see Optional Feature).
- Reset mid-operation: abort to IDLE; no store is committed; READ_DATA is cleared to 0.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access completes with normal timing but performs no write and leaves READ_DATA unchanged. MISALIGNED pulses high for the DONE cycle.
- Undefined: the address is aligned down (addr[0] cleared for H; addr[1:0] cleared for W) and the access is performed. MISALIGNED is tied 0.

Decomposition:
- Package dmem_pkg holds:
  - FUNCT3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding S_IDLE, S_BUSY, S_DONE (2 bits).
  - Function is_misaligned(funct3, addr_lo).
- Sub-module dmem_lane_align: combinational load extract/extend and store byte-enable/data merge. The FSM and array stay in the top module.

Test Plan:
- LATENCY=4. SW 0x12345678 @0x10, then LW @0x10 -> BUSYWAIT high 5 cycles per access with a 1-cycle gap; READ_DATA=0x12345678 at the DONE edge.
- SB 0x80 @0x13, then LB @0x13 and LBU @0x13 -> READ_DATA=0xFFFFFF80 then 0x00000080; LW @0x10 returns 0x80345678.
- SH 0xBEEF @0x22, then LH @0x22 and LHU @0x22 -> 0xFFFFBEEF then 0x0000BEEF; bytes 0x20/0x21 unchanged.
- RESET asserted in the 2nd BUSY cycle of SW 0xDEADBEEF @0x40 -> BUSYWAIT=0 the next cycle, READ_DATA=0; later LW @0x40 returns the prior value.
- LW @0x41: with the macro defined -> MISALIGNED pulses 1 cycle, READ_DATA unchanged. Without it -> returns the word @0x40, MISALIGNED=0.
- DEPTH=256. SW 0xA5A5A5A5 @0x400, then LW @0x000 -> 0xA5A5A5A5 (index wrap).
